// File: rtl/dispctl_pkg.sv
// ---------------------------------------------------------------------------
// dispctl_pkg
// Shared constants and types for the seven-segment display controller.
// A display code is 8 bits: bit7 blank, bit6 decimal point, bit5 dash,
// bits[4:0] character index. The scanner passes codes through untouched.
// The only code it creates itself is BLANK_CODE. It uses BLANK_CODE for
// reset and for the "off" half of a blinking digit.
// ---------------------------------------------------------------------------
package dispctl_pkg;

   typedef logic [7:0] disp_code_t;

   localparam disp_code_t BLANK_CODE = 8'h80;
   localparam disp_code_t DASH_CODE  = 8'h20;

   localparam int BLANK_BIT = 7;
   localparam int DP_BIT    = 6;
   localparam int CHAR_W    = 5;

endpackage

// File: rtl/dispctl_scan_if.sv
// ---------------------------------------------------------------------------
// dispctl_scan_if
// Frame-load port of the display scanner.
//   load      master->slave  capture codes_in/blink_in into staging
//   codes_in  master->slave  digit i code at [8*i+7:8*i]
//   blink_in  master->slave  per-digit blink enable
//   pending   slave->master  staging holds a frame not yet committed
//   load_ack  slave->master  one-cycle pulse when staging is committed
// ---------------------------------------------------------------------------
interface dispctl_scan_if #(
   parameter int NDIGITS = 8
);

   logic                   load;
   logic [8*NDIGITS-1:0]   codes_in;
   logic [NDIGITS-1:0]     blink_in;
   logic                   pending;
   logic                   load_ack;

   modport master (
      output load, codes_in, blink_in,
      input  pending, load_ack
   );

   modport slave (
      input  load, codes_in, blink_in,
      output pending, load_ack
   );

endinterface

// File: rtl/dispctl_scan_rate_enb.sv
// ---------------------------------------------------------------------------
// rate_enb
// Free-running prescaler that counts 0..DIV-1.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   count  out  current prescaler value
//   tc     out  high during the terminal-count cycle (count == DIV-1)
// The count is exported because the scanner uses it for the anode guard window.
// ---------------------------------------------------------------------------
module rate_enb #(
   parameter  int DIV = 100000,
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [CW-1:0] count,
   output logic          tc
);

   // The terminal count is decoded combinationally. The enable is then
   // available in the same cycle as the last count value.
   assign tc = (count == CW'(DIV - 1));

   // Wrap to zero on terminal count. Otherwise increment every clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tc) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dispctl_scan.sv
// ---------------------------------------------------------------------------
// dispctl_scan
// Time-multiplexed driver for an NDIGITS seven-segment display.
// Each digit is selected for CLKS_PER_DIGIT clocks, in round-robin order.
// The first GUARD clocks of each slot keep all anodes off to prevent ghosting.
// New frames are double-buffered. A load writes into staging. At the next
// frame boundary staging is copied into the active set, so the display never
// shows a mix of two frames.
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   host        if   frame-load port (slave side)
//   frame_tick  out  one-cycle pulse after every frame boundary
//   d_out       out  code of the selected digit, to the segment decoder
//   an_n        out  active-low one-hot anode enables
// ---------------------------------------------------------------------------
module dispctl_scan
   import dispctl_pkg::*;
#(
   parameter int NDIGITS        = 8,
   parameter int CLKS_PER_DIGIT = 100000,
   parameter int GUARD          = 4,
   parameter int BLINK_FRAMES   = 125
) (
   input  logic               clk,
   input  logic               rst_n,
   dispctl_scan_if.slave      host,
   output logic               frame_tick,
   output disp_code_t         d_out,
   output logic [NDIGITS-1:0] an_n
);

   localparam int PW = $clog2(CLKS_PER_DIGIT);
   localparam int DW = $clog2(NDIGITS);
   localparam int FW = $clog2(BLINK_FRAMES) + 1;

   logic [PW-1:0]      presc;
   logic               slot_end;
   logic               frame_end;
   logic [DW-1:0]      digit;
   logic [FW-1:0]      frame_cnt;
   logic               blink_phase;

   disp_code_t         staging_codes [NDIGITS];
   disp_code_t         active_codes  [NDIGITS];
   logic [NDIGITS-1:0] staging_blink;
   logic [NDIGITS-1:0] active_blink;
   logic               pending_q;
   logic               load_ack_q;

   logic [NDIGITS-1:0] an_n_next;
   disp_code_t         d_out_next;

   rate_enb #(
      .DIV   (CLKS_PER_DIGIT)
   ) u_slot_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .count (presc),
      .tc    (slot_end)
   );

   assign frame_end     = slot_end && (digit == DW'(NDIGITS - 1));
   assign host.pending  = pending_q;
   assign host.load_ack = load_ack_q;

   // At each slot end, move to the next digit. After the last digit, wrap
   // to digit 0. That wrap is the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
      end else if (slot_end) begin
         if (digit == DW'(NDIGITS - 1)) begin
            digit <= '0;
         end else begin
            digit <= digit + 1'b1;
         end
      end
   end

   // Count frames to run the blink phase. The phase toggles once every
   // BLINK_FRAMES frames. Loading a frame does not reset the phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Double buffer. A load always lands in staging; the last load wins.
   // At a frame boundary with a frame pending, the old staging contents go
   // to active. A load in that same cycle refills staging and keeps pending
   // set, so that data waits for the following boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NDIGITS; i++) begin
            staging_codes[i] <= BLANK_CODE;
            active_codes[i]  <= BLANK_CODE;
         end
         staging_blink <= '0;
         active_blink  <= '0;
         pending_q     <= 1'b0;
         load_ack_q    <= 1'b0;
      end else begin
         load_ack_q <= frame_end && pending_q;
         if (frame_end && pending_q) begin
            active_codes <= staging_codes;
            active_blink <= staging_blink;
         end
         if (host.load) begin
            for (int i = 0; i < NDIGITS; i++) begin
               staging_codes[i] <= host.codes_in[8*i +: 8];
            end
            staging_blink <= host.blink_in;
            pending_q     <= 1'b1;
         end else if (frame_end) begin
            pending_q <= 1'b0;
         end
      end
   end

   // Next-cycle display values. All anodes stay off during the guard window
   // at the start of a slot. A blinking digit is replaced by blank while the
   // blink phase is in its off half.
   always_comb begin
      an_n_next  = '1;
      d_out_next = active_codes[digit];
      if (presc >= PW'(GUARD)) begin
         an_n_next[digit] = 1'b0;
      end
      if (blink_phase && active_blink[digit]) begin
         d_out_next = BLANK_CODE;
      end
   end

   // Display outputs are registered. They follow the internal scan state
   // with one cycle of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_n       <= '1;
         d_out      <= BLANK_CODE;
         frame_tick <= 1'b0;
      end else begin
         an_n       <= an_n_next;
         d_out      <= d_out_next;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_dispctl_scan.sv
// ---------------------------------------------------------------------------
// tb_dispctl_scan
// Directed bench for dispctl_scan with 4 digits, 8 clocks per digit, 2 guard
// clocks and 2 frames per blink half-period. One frame is 32 clocks.
// Expected values are computed by hand per frame.
// ---------------------------------------------------------------------------
module tb_dispctl_scan;
   import dispctl_pkg::*;

   localparam int ND    = 4;
   localparam int CPD   = 8;
   localparam int GD    = 2;
   localparam int BF    = 2;
   localparam int FRAME = ND * CPD;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          frame_tick;
   disp_code_t    d_out;
   logic [ND-1:0] an_n;

   dispctl_scan_if #(.NDIGITS(ND)) host ();

   dispctl_scan #(
      .NDIGITS        (ND),
      .CLKS_PER_DIGIT (CPD),
      .GUARD          (GD),
      .BLINK_FRAMES   (BF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host       (host),
      .frame_tick (frame_tick),
      .d_out      (d_out),
      .an_n       (an_n)
   );

   always #5 clk = ~clk;

   int            checkCount = 0;
   int            passCount  = 0;
   int            k          = -1;
   disp_code_t    expCodes [ND];
   logic [ND-1:0] expBlink;

   // Counts every comparison and reports each mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s (cycle %0d): got 'h%0h, want 'h%0h",
                  tag, k, actual, expected);
      end
   endtask

   // Advances one clock. Sampling and driving happen 1 time unit after the edge.
   task automatic stepClk();
      @(posedge clk);
      k++;
      #1;
   endtask

   task automatic applyStimulus(input logic doLoad, input logic [31:0] codes,
                                input logic [ND-1:0] blink);
      host.load = doLoad;
      if (doLoad) begin
         host.codes_in = codes;
         host.blink_in = blink;
      end
   endtask

   task automatic setExpCodes(input disp_code_t c0, input disp_code_t c1,
                              input disp_code_t c2, input disp_code_t c3);
      expCodes[0] = c0;
      expCodes[1] = c1;
      expCodes[2] = c2;
      expCodes[3] = c3;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_d_out"},      d_out,         8'h80);
      checkOutput({tag, "_an_n"},       an_n,          4'hF);
      checkOutput({tag, "_frame_tick"}, frame_tick,    1'b0);
      checkOutput({tag, "_load_ack"},   host.load_ack, 1'b0);
      checkOutput({tag, "_pending"},    host.pending,  1'b0);
   endtask

   // Runs one full frame with up to two loads (offset -1 means no load).
   // Every cycle is checked against the scan pattern and the expected codes.
   task automatic runFrame(input int offA, input logic [31:0] codesA,
                           input logic [ND-1:0] blinkA,
                           input int offB, input logic [31:0] codesB,
                           input logic [ND-1:0] blinkB,
                           input logic ackExp, input logic pendEnd);
      int            slot;
      int            phase;
      logic [ND-1:0] expAn;
      disp_code_t    expD;
      for (int o = 0; o < FRAME; o++) begin
         if (o == offA) begin
            applyStimulus(1'b1, codesA, blinkA);
         end else if (o == offB) begin
            applyStimulus(1'b1, codesB, blinkB);
         end else begin
            applyStimulus(1'b0, 32'h0, '0);
         end
         stepClk();
         slot  = o / CPD;
         phase = ((k / FRAME) / BF) % 2;
         expAn = ((o % CPD) < GD) ? 4'hF : ~(4'b0001 << slot);
         expD  = (phase == 1 && expBlink[slot]) ? BLANK_CODE : expCodes[slot];
         checkOutput("an_n", an_n, expAn);
         checkOutput("d_out", d_out, expD);
         checkOutput("frame_tick", frame_tick, (o == FRAME - 1));
         checkOutput("load_ack", host.load_ack, (o == FRAME - 1) ? ackExp : 1'b0);
         if (o == offA || o == offB) begin
            checkOutput("pending_after_load", host.pending, 1'b1);
         end
      end
      applyStimulus(1'b0, 32'h0, '0);
      checkOutput("pending_end", host.pending, pendEnd);
   endtask

   initial begin
      host.load     = 1'b0;
      host.codes_in = '0;
      host.blink_in = '0;
      setExpCodes(8'h80, 8'h80, 8'h80, 8'h80);
      expBlink = '0;

      // Assert reset and check the reset values.
      #1 rst_n = 1'b0;
      #1 checkResetState("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k = -1;

      $display("[TB] idle scan");
      runFrame(-1, 32'h0, '0, -1, 32'h0, '0, 1'b0, 1'b0);
      runFrame(-1, 32'h0, '0, -1, 32'h0, '0, 1'b0, 1'b0);

      $display("[TB] single load");
      runFrame(10, 32'h03020100, 4'b0000, -1, 32'h0, '0, 1'b1, 1'b0);
      setExpCodes(8'h00, 8'h01, 8'h02, 8'h03);
      runFrame(-1, 32'h0, '0, -1, 32'h0, '0, 1'b0, 1'b0);

      $display("[TB] two loads in one frame");
      runFrame(5, 32'h0A0A0A0A, 4'b0000, 20, 32'h0B0B0B0B, 4'b0000, 1'b1, 1'b0);
      setExpCodes(8'h0B, 8'h0B, 8'h0B, 8'h0B);

      $display("[TB] load on frame end");
      runFrame(10, 32'h0C0C0C0C, 4'b0000, 31, 32'h0D0D0D0D, 4'b0000, 1'b1, 1'b1);
      setExpCodes(8'h0C, 8'h0C, 8'h0C, 8'h0C);
      runFrame(-1, 32'h0, '0, -1, 32'h0, '0, 1'b1, 1'b0);
      setExpCodes(8'h0D, 8'h0D, 8'h0D, 8'h0D);

      $display("[TB] blink digit 1");
      runFrame(3, 32'h13121110, 4'b0010, -1, 32'h0, '0, 1'b1, 1'b0);
      setExpCodes(8'h10, 8'h11, 8'h12, 8'h13);
      expBlink = 4'b0010;
      for (int f = 0; f < 4; f++) begin
         runFrame(-1, 32'h0, '0, -1, 32'h0, '0, 1'b0, 1'b0);
      end

      $display("[TB] reset mid-slot with pending frame");
      for (int o = 0; o < 14; o++) begin
         applyStimulus(o == 5, 32'h55555555, 4'b0000);
         stepClk();
      end
      applyStimulus(1'b0, 32'h0, '0);
      checkOutput("pending_before_reset", host.pending, 1'b1);
      checkOutput("d_out_before_reset", d_out, 8'h11);
      checkOutput("an_n_before_reset", an_n, 4'b1101);
      #2 rst_n = 1'b0;
      #1 checkResetState("midreset");
      repeat (2) @(posedge clk);
      #1 checkResetState("midreset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      k = -1;
      setExpCodes(8'h80, 8'h80, 8'h80, 8'h80);
      expBlink = '0;
      runFrame(-1, 32'h0, '0, -1, 32'h0, '0, 1'b0, 1'b0);
      runFrame(-1, 32'h0, '0, -1, 32'h0, '0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
